// File: rtl/pc_redirect_unit.sv
// pc_redirect_unit: IF-stage program counter with prioritised next-PC selection.
// Sources, highest first: exception vector, ERET return address, stall hold,
// live branch/jump target, buffered branch target, sequential pc + 4.
// A branch that resolves while fetch is stalled is parked in a one-entry
// buffer and applied on the first unstalled edge without an extra bubble.
// fetch_adel flags the current pc for CP0; this unit never redirects on it.
module pc_redirect_unit #(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(32'h0000_3000),
  parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(32'h0000_4180),
  parameter logic [WIDTH-1:0] ADDR_LO      = WIDTH'(32'h0000_3000),
  parameter logic [WIDTH-1:0] ADDR_HI      = WIDTH'(32'h0000_6FFC)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             br_valid,
  input  logic [WIDTH-1:0] br_target,
  input  logic             exc_valid,
  input  logic             eret_valid,
  input  logic [WIDTH-1:0] epc,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus4,
  output logic             redirect_pending,
  output logic             fetch_adel
);

  logic [WIDTH-1:0] pend_target;
  logic             pend_valid;
  logic [WIDTH-1:0] pc_next;
  logic [WIDTH-1:0] pend_target_next;
  logic             pend_valid_next;

  // Sequential successor wraps modulo 2^WIDTH by plain truncation.
  function automatic logic [WIDTH-1:0] seq_next(input logic [WIDTH-1:0] cur);
    seq_next = cur + WIDTH'(4);
  endfunction

  // Misaligned or outside the legal fetch window (unsigned compare).
  function automatic logic addr_bad(input logic [WIDTH-1:0] a);
    addr_bad = (a[1:0] != 2'b00) || (a < ADDR_LO) || (a > ADDR_HI);
  endfunction

  // Next-state selection by fixed priority; exception and ERET ignore stall.
  always_comb begin
    pc_next          = seq_next(pc);
    pend_valid_next  = pend_valid;
    pend_target_next = pend_target;
    if (exc_valid) begin
      pc_next         = EXC_VECTOR;
      pend_valid_next = 1'b0;
    end else if (eret_valid) begin
      pc_next         = epc;
      pend_valid_next = 1'b0;
    end else if (stall) begin
      pc_next = pc;
      if (br_valid) begin
        // A newer branch overwrites whatever was already buffered.
        pend_valid_next  = 1'b1;
        pend_target_next = br_target;
      end
    end else if (br_valid) begin
      // The live target supersedes any buffered one.
      pc_next         = br_target;
      pend_valid_next = 1'b0;
    end else if (pend_valid) begin
      pc_next         = pend_target;
      pend_valid_next = 1'b0;
    end
  end

  // State registers; reset overrides every other input.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= RESET_VECTOR;
      pend_valid  <= 1'b0;
      pend_target <= '0;
    end else begin
      pc          <= pc_next;
      pend_valid  <= pend_valid_next;
      pend_target <= pend_target_next;
    end
  end

  assign pc_plus4         = seq_next(pc);
  assign fetch_adel       = addr_bad(pc);
  assign redirect_pending = pend_valid;

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Directed bench for pc_redirect_unit: linear sequence of hand-computed steps.
module tb_pc_redirect_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        br_valid;
  logic [31:0] br_target;
  logic        exc_valid;
  logic        eret_valid;
  logic [31:0] epc;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        redirect_pending;
  logic        fetch_adel;

  int tests = 0;
  int fails = 0;

  pc_redirect_unit dut (
    .clk              (clk),
    .reset            (reset),
    .stall            (stall),
    .br_valid         (br_valid),
    .br_target        (br_target),
    .exc_valid        (exc_valid),
    .eret_valid       (eret_valid),
    .epc              (epc),
    .pc               (pc),
    .pc_plus4         (pc_plus4),
    .redirect_pending (redirect_pending),
    .fetch_adel       (fetch_adel)
  );

  always #5 clk = ~clk;

  // Advance one active edge and settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; br_valid = 1'b0; br_target = '0;
    exc_valid = 1'b0; eret_valid = 1'b0; epc = '0;

    // Reset and free-running fetch
    step();
    check("reset_pc", pc, 32'h3000);
    check("reset_pend", {31'd0, redirect_pending}, 32'd0);
    check("reset_adel", {31'd0, fetch_adel}, 32'd0);
    reset = 1'b0;
    step(); check("seq_1", pc, 32'h3004);
    step(); check("seq_2", pc, 32'h3008);
    step(); check("seq_3", pc, 32'h300C);
    check("seq_plus4", pc_plus4, 32'h3010);
    check("seq_pend", {31'd0, redirect_pending}, 32'd0);
    check("seq_adel", {31'd0, fetch_adel}, 32'd0);

    // Branch arriving under a 3-cycle stall
    stall = 1'b1; br_valid = 1'b1; br_target = 32'h3100;
    step(); check("stall_hold_0", pc, 32'h300C);
    check("stall_pend_0", {31'd0, redirect_pending}, 32'd1);
    br_valid = 1'b0;
    step(); check("stall_hold_1", pc, 32'h300C);
    step(); check("stall_hold_2", pc, 32'h300C);
    check("stall_pend_2", {31'd0, redirect_pending}, 32'd1);
    stall = 1'b0;
    step(); check("pend_apply", pc, 32'h3100);
    check("pend_clear", {31'd0, redirect_pending}, 32'd0);
    step(); check("after_pend", pc, 32'h3104);

    // Newer branch overwrites the buffered one
    stall = 1'b1; br_valid = 1'b1; br_target = 32'h3100;
    step();
    br_target = 32'h3200;
    step(); check("overwrite_hold", pc, 32'h3104);
    br_valid = 1'b0; stall = 1'b0;
    step(); check("overwrite_apply", pc, 32'h3200);

    // Live branch on release beats the buffered one
    stall = 1'b1; br_valid = 1'b1; br_target = 32'h3100;
    step(); check("live_pend", {31'd0, redirect_pending}, 32'd1);
    stall = 1'b0; br_target = 32'h3300;
    step(); check("live_wins", pc, 32'h3300);
    check("live_clear", {31'd0, redirect_pending}, 32'd0);

    // Exception during stall drops the pending branch, then ERET
    stall = 1'b1; br_target = 32'h3100;
    step();
    br_valid = 1'b0; exc_valid = 1'b1;
    step(); check("exc_pc", pc, 32'h4180);
    check("exc_pend", {31'd0, redirect_pending}, 32'd0);
    exc_valid = 1'b0; eret_valid = 1'b1; epc = 32'h3008;
    step(); check("eret_pc", pc, 32'h3008);
    eret_valid = 1'b0; stall = 1'b0;
    step(); check("eret_seq", pc, 32'h300C);

    // Priority: exception over ERET, ERET over branch
    exc_valid = 1'b1; eret_valid = 1'b1; epc = 32'h3010;
    step(); check("exc_over_eret", pc, 32'h4180);
    exc_valid = 1'b0; br_valid = 1'b1; br_target = 32'h3300;
    step(); check("eret_over_br", pc, 32'h3010);
    eret_valid = 1'b0;

    // Fetch address exceptions and wrap
    br_target = 32'h3002;
    step(); check("adel_misalign", {31'd0, fetch_adel}, 32'd1);
    check("load_unchecked", pc, 32'h3002);
    br_target = 32'h7000;
    step(); check("adel_above", {31'd0, fetch_adel}, 32'd1);
    br_target = 32'h6FFC;
    step(); check("adel_hi_edge", {31'd0, fetch_adel}, 32'd0);
    check("hi_plus4", pc_plus4, 32'h7000);
    br_target = 32'hFFFF_FFFC;
    step(); check("wrap_plus4", pc_plus4, 32'h0000_0000);
    check("wrap_adel", {31'd0, fetch_adel}, 32'd1);
    br_valid = 1'b0;
    step(); check("wrap_pc", pc, 32'h0000_0000);
    check("adel_below", {31'd0, fetch_adel}, 32'd1);

    // Reset mid-stall with a pending branch
    stall = 1'b1; br_valid = 1'b1; br_target = 32'h3100;
    step(); check("pre_reset_pend", {31'd0, redirect_pending}, 32'd1);
    reset = 1'b1; exc_valid = 1'b1;
    step(); check("midreset_pc", pc, 32'h3000);
    check("midreset_pend", {31'd0, redirect_pending}, 32'd0);
    reset = 1'b0; exc_valid = 1'b0; br_valid = 1'b0; stall = 1'b0;
    step(); check("post_reset_seq", pc, 32'h3004);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pc_redirect_unit.md
# pc_redirect_unit

Parametrised program-counter unit for the pipelined MIPS datapath, replacing the plain stall-able PC register in the IF stage. Holds the fetch PC, selects the next PC from sequential, branch/jump, exception-vector and ERET sources by fixed priority, and buffers a branch redirect that arrives while fetch is stalled. Flags fetch-address exceptions on the current PC for the CP0 path.

## Interface
- WIDTH, 32, PC width in bits; must be at least 3.
- RESET_VECTOR, 32'h0000_3000, PC value loaded on reset.
- EXC_VECTOR, 32'h0000_4180, PC value loaded on exception entry.
- ADDR_LO, 32'h0000_3000, lowest legal fetch address (inclusive).
- ADDR_HI, 32'h0000_6FFC, highest legal fetch address (inclusive).
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- stall  in  1  hold PC (hazard unit); does not block exception or ERET.
- br_valid  in  1  branch/jump taken this cycle.
- br_target  in  WIDTH  branch/jump target.
- exc_valid  in  1  exception/interrupt entry from CP0.
- eret_valid  in  1  ERET retiring.
- epc  in  WIDTH  return address for ERET.
- pc  out  WIDTH  current fetch PC (register).
- pc_plus4  out  WIDTH  pc + 4, modulo 2^WIDTH.
- redirect_pending  out  1  a buffered branch target is waiting (register).
- fetch_adel  out  1  current pc misaligned or outside [ADDR_LO, ADDR_HI].

## Operation
- State: pc register, pend_valid, pend_target (WIDTH).
- Reset: pc = RESET_VECTOR, pend_valid = 0, pend_target = 0; overrides every other input.
- Next-PC priority when not in reset (highest first):
  - exc_valid: pc <= EXC_VECTOR, pend_valid <= 0; regardless of stall, br_valid, eret_valid.
  - eret_valid: pc <= epc, pend_valid <= 0; regardless of stall, br_valid.
  - stall = 1: pc holds; if br_valid, pend_valid <= 1 and pend_target <= br_target (newer overwrites older); else pending unchanged.
  - br_valid (stall = 0): pc <= br_target, pend_valid <= 0 (live target beats buffered one).
  - pend_valid (stall = 0): pc <= pend_target, pend_valid <= 0.
  - otherwise: pc <= pc + 4.
- Arithmetic: pc + 4 truncated to WIDTH bits; WIDTH-max value wraps to low values, no saturation, no flag.
- fetch_adel = (pc[1:0] != 0) or (pc < ADDR_LO) or (pc > ADDR_HI), unsigned compare, combinational from pc register only. Unit does not redirect on its own flag; CP0 answers with exc_valid.
- Targets are not aligned or range-checked on load; a bad target appears as fetch_adel in the following cycle.
- redirect_pending = pend_valid.

## Timing
- All redirects: 1-cycle latency, input sampled at edge N, new pc visible after edge N.
- Buffered branch: applied at first edge with stall = 0, no extra bubble.
- Stall held k cycles with branch at cycle 0: pc unchanged for k edges, target at edge k+1 (first unstalled).
- Exception during stall with pending branch: pending discarded, pc = EXC_VECTOR next edge.
- Reset mid-stall/mid-pending: one edge returns pc to RESET_VECTOR, redirect_pending = 0.
- pc_plus4 and fetch_adel: combinational, valid same cycle as pc, no added latency.

## Test plan
- Reset then 3 free-running cycles -> pc 0x3000, 0x3004, 0x3008, 0x300C; redirect_pending 0; fetch_adel 0.
- stall=1 with br_valid, br_target=0x3100 for 1 cycle, stall held 2 more cycles -> pc stays, redirect_pending 1; release stall -> pc 0x3100, redirect_pending 0.
- Pending 0x3100 then second br_valid 0x3200 while stalled -> after release pc 0x3200; release with br_valid 0x3300 same cycle -> pc 0x3300.
- stall=1, pending set, exc_valid=1 -> pc 0x4180, redirect_pending 0; next cycle eret_valid, epc=0x3008 -> pc 0x3008.
- br_target 0x3002 -> next cycle fetch_adel 1; br_target 0x7000 -> fetch_adel 1; 0x6FFC -> 0; WIDTH=32 pc 0xFFFF_FFFC -> pc_plus4 0x0000_0000.
- reset asserted mid-stall with pending -> pc 0x3000, redirect_pending 0 after one edge.
